// File: rtl/word_bank_demux16_pkg.sv
// Shared constants, FSM state type and bus-packing helper for the 16-slot word bank
// and the matching selector.
package word_bank_demux16_pkg;

    localparam int unsigned WORDS  = 16;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CARD_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Card 0 occupies the most significant word of the packed bus.
    function automatic int unsigned card_lsb(input int unsigned c);
        return (WORDS - 1 - c) * WIDTH;
    endfunction

endpackage

// File: rtl/word_bank_demux16_bank_slot.sv
// One bank entry: data word, flag bit and written-since-clear bit.
// A clear in the same cycle as a write wins.
module bank_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic             i_clr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_flag,
    output logic [WIDTH-1:0] o_data,
    output logic             o_flag,
    output logic             o_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_flag  <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_clr_en) begin
            o_data  <= '0;
            o_flag  <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_wr_en) begin
            o_data  <= i_wr_data;
            o_flag  <= i_wr_flag;
            o_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/word_bank_demux16.sv
// Write side of the 16-way word selector: stores tagged words into a packed bank
// with valid/ready handshake, auto-increment fill and a one-slot-per-cycle clear.
module word_bank_demux16 #(
    parameter int unsigned WORDS  = word_bank_demux16_pkg::WORDS,
    parameter int unsigned WIDTH  = word_bank_demux16_pkg::WIDTH,
    parameter int unsigned CARD_W = word_bank_demux16_pkg::CARD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [CARD_W-1:0]      wr_card,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_flag,
    input  logic                   wr_auto,
    input  logic                   clear_req,
    output logic [WORDS*WIDTH-1:0] out,
    output logic [WORDS-1:0]       flags,
    output logic [WORDS-1:0]       valid_mask,
    output logic                   full,
    output logic                   busy,
    output logic                   err,
    output logic                   clr_done
);

    import word_bank_demux16_pkg::*;

    localparam int unsigned PTR_W = $clog2(WORDS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_clr_cnt;
    logic               r_err;
    logic               r_clr_done;
    logic               w_accept;
    logic               w_tgt_ok;
    logic               w_last_clr;
    logic [CARD_W-1:0]  w_target;
    logic [WORDS-1:0]   w_wr_en;
    logic [WORDS-1:0]   w_clr_en;

    assign wr_ready   = (r_state == IDLE) && !clear_req;
    assign w_accept   = wr_valid && wr_ready;
    assign w_target   = wr_auto ? CARD_W'(r_ptr) : wr_card;
    assign w_tgt_ok   = w_target < CARD_W'(WORDS);
    assign w_last_clr = (r_state == CLEAR) && (r_clr_cnt == PTR_W'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (clear_req)  w_state_nxt = CLEAR;
            CLEAR:   if (w_last_clr) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_clr_cnt  <= '0;
            r_err      <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_err      <= w_accept && !w_tgt_ok;
            r_clr_done <= w_last_clr;
            if (r_state == CLEAR)
                r_clr_cnt <= w_last_clr ? '0 : r_clr_cnt + 1'b1;
            // No accept can occur while clearing, so the pointer reset never races a fill.
            if (w_last_clr)
                r_ptr <= '0;
            else if (w_accept && wr_auto)
                r_ptr <= r_ptr + 1'b1;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_slot
        assign w_wr_en[g]  = w_accept && w_tgt_ok && (w_target == CARD_W'(g));
        assign w_clr_en[g] = (r_state == CLEAR) && (r_clr_cnt == PTR_W'(g));

        bank_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_en   (w_wr_en[g]),
            .i_clr_en  (w_clr_en[g]),
            .i_wr_data (wr_data),
            .i_wr_flag (wr_flag),
            .o_data    (out[card_lsb(g) +: WIDTH]),
            .o_flag    (flags[WORDS-1-g]),
            .o_valid   (valid_mask[WORDS-1-g])
        );
    end

    assign full     = &valid_mask;
    assign busy     = (r_state == CLEAR);
    assign err      = r_err;
    assign clr_done = r_clr_done;

endmodule

// File: tb/tb_word_bank_demux16.sv
// Self-checking bench for word_bank_demux16: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_word_bank_demux16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [4:0]   wr_card;
    logic [31:0]  wr_data;
    logic         wr_flag;
    logic         wr_auto;
    logic         clear_req;
    logic [511:0] out;
    logic [15:0]  flags;
    logic [15:0]  valid_mask;
    logic         full;
    logic         busy;
    logic         err;
    logic         clr_done;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: plain arrays, a fill pointer and a clear position (-1 = not clearing).
    logic [31:0] m_data  [16];
    logic        m_flag  [16];
    logic        m_valid [16];
    int          m_ptr;
    int          m_clr;
    logic        m_err;
    logic        m_done;

    always #5 clk = ~clk;

    word_bank_demux16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_card    (wr_card),
        .wr_data    (wr_data),
        .wr_flag    (wr_flag),
        .wr_auto    (wr_auto),
        .clear_req  (clear_req),
        .out        (out),
        .flags      (flags),
        .valid_mask (valid_mask),
        .full       (full),
        .busy       (busy),
        .err        (err),
        .clr_done   (clr_done)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_data[i]  = '0;
            m_flag[i]  = 1'b0;
            m_valid[i] = 1'b0;
        end
        m_ptr  = 0;
        m_clr  = -1;
        m_err  = 1'b0;
        m_done = 1'b0;
    endtask

    function automatic logic model_ready();
        return (m_clr < 0) && !clear_req;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        int tgt;
        m_err  = 1'b0;
        m_done = 1'b0;
        if (m_clr >= 0) begin
            m_data[m_clr]  = '0;
            m_flag[m_clr]  = 1'b0;
            m_valid[m_clr] = 1'b0;
            if (m_clr == 15) begin
                m_clr  = -1;
                m_ptr  = 0;
                m_done = 1'b1;
            end else begin
                m_clr++;
            end
        end else if (clear_req) begin
            m_clr = 0;
        end else if (wr_valid) begin
            tgt = wr_auto ? m_ptr : int'(wr_card);
            if (tgt < 16) begin
                m_data[tgt]  = wr_data;
                m_flag[tgt]  = wr_flag;
                m_valid[tgt] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            if (wr_auto) m_ptr = (m_ptr + 1) % 16;
        end
    endtask

    task automatic check_all(input string tag);
        logic [511:0] e_out;
        logic [15:0]  e_flags;
        logic [15:0]  e_mask;
        e_out = '0;
        for (int c = 0; c < 16; c++) begin
            e_out[511 - 32*c -: 32] = m_data[c];
            e_flags[15 - c]         = m_flag[c];
            e_mask[15 - c]          = m_valid[c];
        end
        chk({tag, ".out"},      out,        e_out);
        chk({tag, ".flags"},    flags,      e_flags);
        chk({tag, ".mask"},     valid_mask, e_mask);
        chk({tag, ".full"},     full,       e_mask == 16'hFFFF);
        chk({tag, ".busy"},     busy,       m_clr >= 0);
        chk({tag, ".err"},      err,        m_err);
        chk({tag, ".clr_done"}, clr_done,   m_done);
    endtask

    // Drive one cycle of inputs, check wr_ready before the edge and all outputs after it.
    task automatic cycle(input string tag, input logic v, input logic [4:0] card,
                         input logic [31:0] d, input logic f, input logic a, input logic c);
        wr_valid  = v;
        wr_card   = card;
        wr_data   = d;
        wr_flag   = f;
        wr_auto   = a;
        clear_req = c;
        #1;
        chk({tag, ".ready"}, wr_ready, model_ready());
        @(posedge clk);
        model_edge();
        #2;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_card   = '0;
        wr_data   = '0;
        wr_flag   = 1'b0;
        wr_auto   = 1'b0;
        clear_req = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        chk("reset.ready", wr_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed writes to the end cards
        cycle("w_card0", 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk("card0_word", out[511:480], 32'hDEADBEEF);
        chk("card0_mask", valid_mask, 16'h8000);
        chk("card0_flag", flags[15], 1'b1);
        cycle("w_card15", 1'b1, 5'd15, 32'h1, 1'b0, 1'b0, 1'b0);
        chk("card15_word", out[31:0], 32'h1);
        chk("card15_mask", valid_mask, 16'h8001);

        // Invalid card: handshake completes, bank untouched, one-cycle err
        cycle("w_bad", 1'b1, 5'd20, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("bad_err", err, 1'b1);
        cycle("bad_after", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("bad_err_gone", err, 1'b0);

        // 17 auto beats: fills the bank then wraps onto card 0
        for (int i = 0; i < 17; i++) begin
            cycle("auto", 1'b1, 5'd31, 32'(i), i[0], 1'b1, 1'b0);
            if (i == 15) chk("auto_full", full, 1'b1);
        end
        chk("auto_wrap_card0", out[511:480], 32'd16);
        cycle("auto_ptr1", 1'b1, 5'd0, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0);
        chk("auto_ptr1_card1", out[479:448], 32'hA5A5_0001);

        // Clear with a competing write; 16 clear cycles then a single done pulse
        cycle("clr_start", 1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        chk("clr_start_busy", busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle("clearing", 1'b1, 5'd2, 32'hCAFE_0000, 1'b1, 1'b0, i == 4);
            if (i == 0)  chk("clr_first_mask", valid_mask, 16'h7FFF);
            if (i == 14) chk("clr_still_busy", busy, 1'b1);
        end
        chk("clr_end_mask", valid_mask, 16'h0000);
        chk("clr_done_pulse", clr_done, 1'b1);
        cycle("clr_idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("clr_done_single", clr_done, 1'b0);

        // Async reset in the middle of a clear
        for (int i = 0; i < 4; i++)
            cycle("prefill", 1'b1, 5'd0, $urandom, 1'b1, 1'b1, 1'b0);
        cycle("clr2_start", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++)
            cycle("clr2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 5'd9, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
        chk("post_rst_ptr0", out[511:480], 32'h0BAD_F00D);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 19)),
                  $urandom, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
